dqs_amble_shifter: RTL and testbench

Parametrised DQS preamble/interamble/postamble generator for the DDR5 PHY write path. It sits between the write manager and the DQS serializer. From an early write-window enable it emits 2 UI of DQS per clock:
- a programmable-length preamble;
- toggles during data;
- a programmable postamble;
- a merged interamble when two bursts are too close for a full post+pre sequence.

It also measures the low gap between bursts.

---
 rtl/dqs_pkg.sv | 15 +
 rtl/dqs_lookahead.sv | 36 +++
 rtl/dqs_amble_shifter.sv | 152 +++++++++++++++
 tb/tb_dqs_amble_shifter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dqs_pkg.sv
// rtl/dqs_pkg.sv - shared DQS phase encoding and UI pair constants
package dqs_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PRE   = 3'd1,
      DATA  = 3'd2,
      INTER = 3'd3,
      POST  = 3'd4
   } dqs_phase_e;

   localparam logic [1:0] DQS_TOGGLE = 2'b10;
   localparam logic [1:0] DQS_IDLE   = 2'b00;

endpackage

// File: rtl/dqs_lookahead.sv
// rtl/dqs_lookahead.sv - write-enable history and distance to the next data slot
// hist[D-1] is the current slot; k counts clocks until the nearest set bit below it.
module dqs_lookahead #(
   parameter int D = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_en,
   output logic [D-1:0]         hist,
   output logic [$clog2(D)-1:0] k,
   output logic                 k_valid
);

   localparam int KW = $clog2(D);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist <= '0;
      end else begin
         hist <= {hist[D-2:0], wr_en};
      end
   end

   // Scan far-to-near so the closest pending slot wins.
   always_comb begin
      k       = '0;
      k_valid = 1'b0;
      for (int j = D - 1; j >= 1; j--) begin
         if (hist[D-1-j]) begin
            k       = KW'(j);
            k_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dqs_amble_shifter.sv
// rtl/dqs_amble_shifter.sv - DQS preamble/interamble/postamble generator
// Define DQS_GAP_MONITOR_EN to build the low-gap measurement (o_gap/o_gap_valid).
module dqs_amble_shifter
   import dqs_pkg::*;
#(
   parameter int PRE_CYC  = 4,
   parameter int POST_CYC = 2,
   parameter int GAP_W    = 3
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic                            i_wr_en,
   input  logic [2*PRE_CYC-1:0]            i_pre_pattern,
   input  logic [$clog2(PRE_CYC+1)-1:0]    i_pre_len,
   input  logic [2*POST_CYC-1:0]           i_post_pattern,
   input  logic [$clog2(POST_CYC+1)-1:0]   i_post_len,
   output logic [1:0]                      o_dqs_bits,
   output logic                            o_dqs_oe,
   output logic [2:0]                      o_phase,
   output logic [GAP_W-1:0]                o_gap,
   output logic                            o_gap_valid
);

   localparam int D     = PRE_CYC + 1;
   localparam int KW    = $clog2(D);
   localparam int M_SAT = POST_CYC + PRE_CYC + 1;
   localparam int MW    = $clog2(M_SAT + 1);
   localparam logic [MW-1:0] M_SAT_V = MW'(M_SAT);

   logic [D-1:0]                    hist;
   logic [KW-1:0]                   k;
   logic                            k_valid;
   logic [MW-1:0]                   m_q;
   logic [MW-1:0]                   m_now;
   logic [2*PRE_CYC-1:0]            pre_pat_s;
   logic [$clog2(PRE_CYC+1)-1:0]    pre_len_s;
   logic [2*POST_CYC-1:0]           post_pat_s;
   logic [$clog2(POST_CYC+1)-1:0]   post_len_s;
   logic                            idle;
   logic                            pre_hit;
   logic                            post_hit;
   logic [1:0]                      pre_bits;
   logic [1:0]                      post_bits;
   dqs_phase_e                      nxt_phase;
   logic [1:0]                      nxt_bits;
   logic                            nxt_oe;
   int                              kk, mm, pl, ql;

   dqs_lookahead #(.D(D)) u_lookahead (
      .clk     (i_clk),
      .rst_n   (i_rst),
      .wr_en   (i_wr_en),
      .hist    (hist),
      .k       (k),
      .k_valid (k_valid)
   );

   assign idle = (hist == '0) && (m_q == M_SAT_V);

   always_comb begin
      m_now = hist[D-1] ? '0 : ((m_q == M_SAT_V) ? m_q : m_q + 1'b1);
      kk    = int'(k);
      mm    = int'(m_now);
      pl    = int'(pre_len_s);
      ql    = int'(post_len_s);
      pre_hit  = k_valid && (kk <= pl);
      post_hit = (mm >= 1) && (mm <= ql);
      // Pairs are taken most-significant first from the low 2*len bits.
      pre_bits  = 2'(pre_pat_s >> (pre_hit ? 2 * (kk - 1) : 0));
      post_bits = 2'(post_pat_s >> (post_hit ? 2 * (ql - mm) : 0));

      nxt_phase = IDLE;
      nxt_bits  = DQS_IDLE;
      nxt_oe    = 1'b0;
      if (hist[D-1]) begin
         nxt_phase = DATA;
         nxt_bits  = DQS_TOGGLE;
         nxt_oe    = 1'b1;
      end else if (k_valid && (mm < M_SAT) && (mm + kk - 1 <= pl + ql)) begin
         nxt_phase = INTER;
         nxt_oe    = 1'b1;
         if (pre_hit) begin
            nxt_bits = pre_bits;
         end else if (post_hit) begin
            nxt_bits = post_bits;
         end
      end else if (pre_hit) begin
         nxt_phase = PRE;
         nxt_bits  = pre_bits;
         nxt_oe    = 1'b1;
      end else if (post_hit) begin
         nxt_phase = POST;
         nxt_bits  = post_bits;
         nxt_oe    = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         m_q        <= M_SAT_V;
         pre_pat_s  <= '0;
         pre_len_s  <= '0;
         post_pat_s <= '0;
         post_len_s <= '0;
         o_dqs_bits <= DQS_IDLE;
         o_dqs_oe   <= 1'b0;
         o_phase    <= IDLE;
      end else begin
         m_q <= m_now;
         // Shadow config only moves while nothing is in flight.
         if (idle) begin
            pre_pat_s  <= i_pre_pattern;
            pre_len_s  <= i_pre_len;
            post_pat_s <= i_post_pattern;
            post_len_s <= i_post_len;
         end
         o_dqs_bits <= nxt_bits;
         o_dqs_oe   <= nxt_oe;
         o_phase    <= nxt_phase;
      end
   end

`ifdef DQS_GAP_MONITOR_EN
   logic [GAP_W-1:0] gap_cnt;
   logic             seen_high;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         gap_cnt     <= '0;
         seen_high   <= 1'b0;
         o_gap       <= '0;
         o_gap_valid <= 1'b0;
      end else begin
         o_gap_valid <= 1'b0;
         if (i_wr_en) begin
            seen_high <= 1'b1;
            gap_cnt   <= '0;
            if (seen_high && (gap_cnt != '0)) begin
               o_gap       <= gap_cnt;
               o_gap_valid <= 1'b1;
            end
         end else if (gap_cnt != '1) begin
            gap_cnt <= gap_cnt + 1'b1;
         end
      end
   end
`else
   assign o_gap       = '0;
   assign o_gap_valid = 1'b0;
`endif

endmodule

// File: tb/tb_dqs_amble_shifter.sv
// tb/tb_dqs_amble_shifter.sv - scoreboard bench for dqs_amble_shifter
module tb_dqs_amble_shifter;
   import dqs_pkg::*;

`ifdef DQS_GAP_MONITOR_EN
   localparam bit GAP_ON = 1'b1;
`else
   localparam bit GAP_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_wr_en = 1'b0;
   logic [7:0] i_pre_pattern = 8'h02;
   logic [2:0] i_pre_len = 3'd2;
   logic [3:0] i_post_pattern = 4'h0;
   logic [1:0] i_post_len = 2'd1;
   logic [1:0] o_dqs_bits;
   logic       o_dqs_oe;
   logic [2:0] o_phase;
   logic [2:0] o_gap;
   logic       o_gap_valid;

   typedef struct {
      int         cyc;
      logic [2:0] ph;
      logic [1:0] bits;
      logic       oe;
   } exp_t;

   exp_t exp_q[$];
   int   gap_q[$];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   b;

   dqs_amble_shifter #(.PRE_CYC(4), .POST_CYC(2), .GAP_W(3)) dut (
      .i_clk          (clk),
      .i_rst          (i_rst),
      .i_wr_en        (i_wr_en),
      .i_pre_pattern  (i_pre_pattern),
      .i_pre_len      (i_pre_len),
      .i_post_pattern (i_post_pattern),
      .i_post_len     (i_post_len),
      .o_dqs_bits     (o_dqs_bits),
      .o_dqs_oe       (o_dqs_oe),
      .o_phase        (o_phase),
      .o_gap          (o_gap),
      .o_gap_valid    (o_gap_valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void ex(int base, int c, logic [2:0] ph, logic [1:0] bits, logic oe);
      exp_q.push_back('{base + c, ph, bits, oe});
   endfunction

   function automatic void exr(int base, int c0, int c1, logic [2:0] ph, logic [1:0] bits, logic oe);
      for (int c = c0; c <= c1; c++) ex(base, c, ph, bits, oe);
   endfunction

   function automatic void gx(int g);
      if (GAP_ON) gap_q.push_back(g);
   endfunction

   task automatic chk(string name, int got, int want);
      n_tests++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic start(output int base);
      @(negedge clk);
      base = cyc;
   endtask

   task automatic drive(input logic [31:0] pat, input int len);
      for (int i = 0; i < len; i++) begin
         i_wr_en = pat[i];
         @(negedge clk);
      end
      i_wr_en = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Monitor: tag = edge index whose registered output is now visible.
   always @(negedge clk) begin
      exp_t e;
      while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
         e = exp_q.pop_front();
         n_tests++;
         if (e.cyc != cyc - 1 || o_phase != e.ph || o_dqs_bits != e.bits || o_dqs_oe != e.oe) begin
            n_fail++;
            $display("FAIL dqs@%0d: got ph=%0d bits=%b oe=%b want ph=%0d bits=%b oe=%b (at %0d)",
                     e.cyc, o_phase, o_dqs_bits, o_dqs_oe, e.ph, e.bits, e.oe, cyc - 1);
         end
      end
      if (o_gap_valid) begin
         n_tests++;
         if (gap_q.size() == 0) begin
            n_fail++;
            $display("FAIL gap_pulse: got unexpected pulse gap=%0d want none", o_gap);
         end else if (o_gap != 3'(gap_q[0])) begin
            n_fail++;
            $display("FAIL gap_value: got %0d want %0d", o_gap, gap_q[0]);
            void'(gap_q.pop_front());
         end else begin
            void'(gap_q.pop_front());
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      #2 i_rst = 1'b0;
      #1;
      chk("rst_phase", int'(o_phase), int'(IDLE));
      chk("rst_bits", int'(o_dqs_bits), 0);
      chk("rst_oe", int'(o_dqs_oe), 0);
      chk("rst_gap", int'(o_gap), 0);
      chk("rst_gap_valid", int'(o_gap_valid), 0);
      idle(3);
      i_rst = 1'b1;
      idle(4);

      // single burst
      start(b);
      ex(b, 2, IDLE, 2'b00, 1'b0);
      ex(b, 3, PRE, 2'b00, 1'b1);
      ex(b, 4, PRE, 2'b10, 1'b1);
      exr(b, 5, 8, DATA, 2'b10, 1'b1);
      ex(b, 9, POST, 2'b00, 1'b1);
      ex(b, 10, IDLE, 2'b00, 1'b0);
      drive(32'h00F, 4);
      idle(16);

      // one-clock gap
      start(b);
      gx(7); gx(1);
      ex(b, 3, PRE, 2'b00, 1'b1);
      ex(b, 4, PRE, 2'b10, 1'b1);
      exr(b, 5, 8, DATA, 2'b10, 1'b1);
      ex(b, 9, INTER, 2'b10, 1'b1);
      exr(b, 10, 13, DATA, 2'b10, 1'b1);
      ex(b, 14, POST, 2'b00, 1'b1);
      ex(b, 15, IDLE, 2'b00, 1'b0);
      drive(32'h1EF, 9);
      idle(16);

      // three-clock gap
      start(b);
      gx(7); gx(3);
      exr(b, 5, 8, DATA, 2'b10, 1'b1);
      ex(b, 9, INTER, 2'b00, 1'b1);
      ex(b, 10, INTER, 2'b00, 1'b1);
      ex(b, 11, INTER, 2'b10, 1'b1);
      exr(b, 12, 13, DATA, 2'b10, 1'b1);
      ex(b, 14, POST, 2'b00, 1'b1);
      ex(b, 15, IDLE, 2'b00, 1'b0);
      drive(32'h18F, 9);
      idle(16);

      // five-clock gap
      start(b);
      gx(7); gx(5);
      exr(b, 5, 8, DATA, 2'b10, 1'b1);
      ex(b, 9, POST, 2'b00, 1'b1);
      exr(b, 10, 11, IDLE, 2'b00, 1'b0);
      ex(b, 12, PRE, 2'b00, 1'b1);
      ex(b, 13, PRE, 2'b10, 1'b1);
      exr(b, 14, 15, DATA, 2'b10, 1'b1);
      ex(b, 16, POST, 2'b00, 1'b1);
      ex(b, 17, IDLE, 2'b00, 1'b0);
      drive(32'h60F, 11);
      idle(16);

      // nine-clock gap saturates the measurement
      start(b);
      gx(7); gx(7);
      exr(b, 5, 6, DATA, 2'b10, 1'b1);
      ex(b, 7, POST, 2'b00, 1'b1);
      ex(b, 8, IDLE, 2'b00, 1'b0);
      ex(b, 14, PRE, 2'b00, 1'b1);
      ex(b, 15, PRE, 2'b10, 1'b1);
      ex(b, 16, DATA, 2'b10, 1'b1);
      ex(b, 17, POST, 2'b00, 1'b1);
      ex(b, 18, IDLE, 2'b00, 1'b0);
      drive(32'h803, 12);
      idle(16);

      // config change mid-burst must not affect this burst's postamble
      start(b);
      gx(7);
      ex(b, 3, PRE, 2'b00, 1'b1);
      ex(b, 4, PRE, 2'b10, 1'b1);
      exr(b, 5, 8, DATA, 2'b10, 1'b1);
      ex(b, 9, POST, 2'b00, 1'b1);
      ex(b, 10, IDLE, 2'b00, 1'b0);
      drive(32'h00F, 6);
      i_pre_len = 3'd4;
      i_pre_pattern = 8'h1B;
      i_post_len = 2'd2;
      i_post_pattern = 4'hB;
      idle(20);

      // new config after idle: 4-clock preamble, 2-clock postamble
      start(b);
      gx(7);
      ex(b, 0, IDLE, 2'b00, 1'b0);
      ex(b, 1, PRE, 2'b00, 1'b1);
      ex(b, 2, PRE, 2'b01, 1'b1);
      ex(b, 3, PRE, 2'b10, 1'b1);
      ex(b, 4, PRE, 2'b11, 1'b1);
      exr(b, 5, 6, DATA, 2'b10, 1'b1);
      ex(b, 7, POST, 2'b10, 1'b1);
      ex(b, 8, POST, 2'b11, 1'b1);
      ex(b, 9, IDLE, 2'b00, 1'b0);
      drive(32'h003, 2);
      idle(18);

      // interamble where preamble takes priority over postamble
      start(b);
      gx(7); gx(3);
      ex(b, 1, PRE, 2'b00, 1'b1);
      ex(b, 2, PRE, 2'b01, 1'b1);
      ex(b, 3, PRE, 2'b10, 1'b1);
      ex(b, 4, PRE, 2'b11, 1'b1);
      ex(b, 5, DATA, 2'b10, 1'b1);
      ex(b, 6, INTER, 2'b01, 1'b1);
      ex(b, 7, INTER, 2'b10, 1'b1);
      ex(b, 8, INTER, 2'b11, 1'b1);
      ex(b, 9, DATA, 2'b10, 1'b1);
      ex(b, 10, POST, 2'b10, 1'b1);
      ex(b, 11, POST, 2'b11, 1'b1);
      ex(b, 12, IDLE, 2'b00, 1'b0);
      drive(32'h011, 5);
      i_pre_len = 3'd2;
      i_pre_pattern = 8'h02;
      i_post_len = 2'd1;
      i_post_pattern = 4'h0;
      idle(20);

      // reset mid-burst
      start(b);
      gx(7);
      ex(b, 3, PRE, 2'b00, 1'b1);
      ex(b, 4, PRE, 2'b10, 1'b1);
      ex(b, 5, DATA, 2'b10, 1'b1);
      exr(b, 8, 12, IDLE, 2'b00, 1'b0);
      drive(32'h00F, 7);
      chk("gap_before_rst", int'(o_gap), GAP_ON ? 7 : 0);
      #1 i_rst = 1'b0;
      #1;
      chk("midrst_phase", int'(o_phase), int'(IDLE));
      chk("midrst_bits", int'(o_dqs_bits), 0);
      chk("midrst_oe", int'(o_dqs_oe), 0);
      chk("midrst_gap", int'(o_gap), 0);
      chk("midrst_gap_valid", int'(o_gap_valid), 0);
      @(negedge clk);
      i_rst = 1'b1;
      idle(10);

      chk("exp_q_drained", exp_q.size(), 0);
      chk("gap_q_drained", gap_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
